// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin arbiter granting one of two cache controllers a whole line refill on the shared memory port
module cache_mem_arbiter #(
  parameter int ADR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_OFFSET = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_c0,
  input  logic                   req_c1,
  input  logic [ADR_WIDTH-1:0]   adr_c0,
  input  logic [ADR_WIDTH-1:0]   adr_c1,
  output logic                   ack_arb2c0,
  output logic                   ack_arb2c1,
  output logic [DATA_WIDTH-1:0]  dat_arb2c0,
  output logic [DATA_WIDTH-1:0]  dat_arb2c1,
  output logic [WORD_OFFSET-1:0] word_arb2c0,
  output logic [WORD_OFFSET-1:0] word_arb2c1,
  output logic                   last_arb2c0,
  output logic                   last_arb2c1,
  output logic                   gnt_c0,
  output logic                   gnt_c1,
  output logic                   req_arb2mem,
  output logic [ADR_WIDTH-1:0]   adr_arb2mem,
  input  logic                   ack_mem2arb,
  input  logic [DATA_WIDTH-1:0]  dat_mem2arb,
  output logic                   err_arb
);
  localparam int LW = ADR_WIDTH - WORD_OFFSET - 2;
  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;
  state_t state;
  logic prio;
  logic [WORD_OFFSET-1:0] beat;
  logic [LW-1:0] line;
  logic pick, beat_ack, unused_adr_bits;
  assign unused_adr_bits = ^{adr_c0[WORD_OFFSET+1:0], adr_c1[WORD_OFFSET+1:0]};
  assign pick = (req_c0 && req_c1) ? prio : req_c1;
  assign beat_ack = !rst && state == XFER && ack_mem2arb;
  assign ack_arb2c0 = beat_ack && gnt_c0;
  assign ack_arb2c1 = beat_ack && gnt_c1;
  assign dat_arb2c0 = ack_arb2c0 ? dat_mem2arb : '0;
  assign dat_arb2c1 = ack_arb2c1 ? dat_mem2arb : '0;
  assign word_arb2c0 = ack_arb2c0 ? beat : '0;
  assign word_arb2c1 = ack_arb2c1 ? beat : '0;
  assign last_arb2c0 = ack_arb2c0 && (&beat);
  assign last_arb2c1 = ack_arb2c1 && (&beat);
  assign adr_arb2mem = {line, beat, 2'b00};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      beat <= '0;
      line <= '0;
      gnt_c0 <= 1'b0;
      gnt_c1 <= 1'b0;
      req_arb2mem <= 1'b0;
      err_arb <= 1'b0;
    end else begin
      err_arb <= err_arb || (ack_mem2arb && state != XFER);
      case (state)
        IDLE: if (req_c0 || req_c1) begin
          state <= XFER;
          gnt_c0 <= !pick;
          gnt_c1 <= pick;
          req_arb2mem <= 1'b1;
          beat <= '0;
          line <= pick ? adr_c1[ADR_WIDTH-1:WORD_OFFSET+2] : adr_c0[ADR_WIDTH-1:WORD_OFFSET+2];
        end
        XFER: if (ack_mem2arb) begin
          beat <= beat + 1'b1;
          if (&beat) begin
            state <= RELEASE;
            prio <= gnt_c0;
            gnt_c0 <= 1'b0;
            gnt_c1 <= 1'b0;
            req_arb2mem <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scoreboard bench for the two-controller line refill arbiter
module tb_cache_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req_c0 = 1'b0, req_c1 = 1'b0;
  logic [31:0] adr_c0 = '0, adr_c1 = '0;
  logic ack_arb2c0, ack_arb2c1, last_arb2c0, last_arb2c1;
  logic [31:0] dat_arb2c0, dat_arb2c1;
  logic [1:0] word_arb2c0, word_arb2c1;
  logic gnt_c0, gnt_c1, req_arb2mem, err_arb;
  logic [31:0] adr_arb2mem;
  logic ack_mem2arb = 1'b0;
  logic [31:0] dat_mem2arb = '0;
  int tests = 0, fails = 0;
  typedef struct {
    bit c;
    logic [31:0] d;
    logic [1:0] w;
    logic l;
  } exp_t;
  exp_t sb[$];
  logic [31:0] t1_data [4] = '{32'h754CD4A5, 32'h75CCD4BD, 32'h754CB4A5, 32'h7540D4A5};
  always #5 clk = ~clk;
  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_c0(req_c0), .req_c1(req_c1), .adr_c0(adr_c0), .adr_c1(adr_c1),
    .ack_arb2c0(ack_arb2c0), .ack_arb2c1(ack_arb2c1),
    .dat_arb2c0(dat_arb2c0), .dat_arb2c1(dat_arb2c1),
    .word_arb2c0(word_arb2c0), .word_arb2c1(word_arb2c1),
    .last_arb2c0(last_arb2c0), .last_arb2c1(last_arb2c1),
    .gnt_c0(gnt_c0), .gnt_c1(gnt_c1),
    .req_arb2mem(req_arb2mem), .adr_arb2mem(adr_arb2mem),
    .ack_mem2arb(ack_mem2arb), .dat_mem2arb(dat_mem2arb),
    .err_arb(err_arb)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt_c0"}, gnt_c0, 0);
    chk({tag, "_gnt_c1"}, gnt_c1, 0);
    chk({tag, "_req_mem"}, req_arb2mem, 0);
  endtask
  task automatic beat(input bit c, input logic [31:0] a, input logic [31:0] d, input int gap, input logic [1:0] w);
    repeat (gap) tick();
    chk("adr_mem", adr_arb2mem, a);
    chk("gnt_granted", c ? gnt_c1 : gnt_c0, 1);
    chk("gnt_other", c ? gnt_c0 : gnt_c1, 0);
    chk("req_mem", req_arb2mem, 1);
    ack_mem2arb = 1'b1;
    dat_mem2arb = d;
    sb.push_back(exp_t'{c, d, w, w == 2'd3});
    tick();
    ack_mem2arb = 1'b0;
    dat_mem2arb = '0;
  endtask
  task automatic burst(input bit c, input logic [31:0] base, input int gap, input int first, input int n);
    for (int i = first; i < first + n; i++) beat(c, base + 32'(i * 4), $urandom, gap, 2'(i));
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (ack_arb2c0 || ack_arb2c1) begin
      if (sb.size() == 0) chk("unexpected_ack", {30'd0, ack_arb2c1, ack_arb2c0}, 0);
      else begin
        e = sb.pop_front();
        chk("ack_c0", ack_arb2c0, !e.c);
        chk("ack_c1", ack_arb2c1, e.c);
        chk("dat", e.c ? dat_arb2c1 : dat_arb2c0, e.d);
        chk("dat_other", e.c ? dat_arb2c0 : dat_arb2c1, 0);
        chk("word", e.c ? word_arb2c1 : word_arb2c0, e.w);
        chk("last", e.c ? last_arb2c1 : last_arb2c0, e.l);
        chk("last_other", e.c ? last_arb2c0 : last_arb2c1, 0);
      end
    end else begin
      chk("idle_dat", dat_arb2c0 | dat_arb2c1, 0);
      chk("idle_word", {word_arb2c0, word_arb2c1}, 0);
      chk("idle_last", {last_arb2c0, last_arb2c1}, 0);
    end
  end
  initial begin
    tick();
    do_reset();
    chk_quiet("rst");
    chk("rst_adr", adr_arb2mem, 0);
    chk("rst_err", err_arb, 0);
    req_c0 = 1'b1;
    adr_c0 = 32'h00CC3B40;
    adr_c1 = 32'h12345670;
    tick();
    chk("t1_gnt_c0", gnt_c0, 1);
    for (int i = 0; i < 4; i++) beat(0, 32'h00CC3B40 + 32'(i * 4), t1_data[i], 3, 2'(i));
    req_c0 = 1'b0;
    chk_quiet("t1_release");
    tick();
    tick();
    chk_quiet("t1_idle");
    do_reset();
    req_c0 = 1'b1;
    req_c1 = 1'b1;
    adr_c0 = 32'h0000A100;
    adr_c1 = 32'h0000B200;
    tick();
    burst(0, 32'h0000A100, 1, 0, 4);
    chk_quiet("t2_release");
    tick();
    chk_quiet("t2_idle");
    tick();
    burst(1, 32'h0000B200, 0, 0, 4);
    tick();
    tick();
    burst(0, 32'h0000A100, 0, 0, 4);
    req_c0 = 1'b0;
    req_c1 = 1'b0;
    tick();
    tick();
    chk_quiet("t2_end");
    req_c1 = 1'b1;
    adr_c1 = 32'h0000C340;
    tick();
    burst(1, 32'h0000C340, 1, 0, 2);
    req_c1 = 1'b0;
    adr_c1 = 32'hFFFFFFF0;
    burst(1, 32'h0000C340, 2, 2, 2);
    chk_quiet("t3_release");
    tick();
    tick();
    chk_quiet("t3_idle");
    chk("t4_err_before", err_arb, 0);
    ack_mem2arb = 1'b1;
    dat_mem2arb = 32'hDEADBEEF;
    #1;
    chk("t4_no_ack", {ack_arb2c0, ack_arb2c1}, 0);
    tick();
    ack_mem2arb = 1'b0;
    dat_mem2arb = '0;
    chk("t4_err_set", err_arb, 1);
    repeat (3) tick();
    chk("t4_err_sticky", err_arb, 1);
    do_reset();
    chk("t4_err_clr", err_arb, 0);
    req_c0 = 1'b1;
    adr_c0 = 32'h00400010;
    tick();
    burst(0, 32'h00400010, 1, 0, 4);
    tick();
    tick();
    burst(0, 32'h00400010, 1, 0, 3);
    rst = 1'b1;
    ack_mem2arb = 1'b1;
    dat_mem2arb = 32'h0BADF00D;
    #1;
    chk("t5_rst_cycle_ack", {ack_arb2c0, ack_arb2c1}, 0);
    tick();
    rst = 1'b0;
    ack_mem2arb = 1'b0;
    dat_mem2arb = '0;
    chk_quiet("t5_after_rst");
    chk("t5_adr", adr_arb2mem, 0);
    chk("t5_err", err_arb, 0);
    req_c1 = 1'b1;
    adr_c1 = 32'h00500020;
    tick();
    chk("t5_prio_c0", gnt_c0, 1);
    burst(0, 32'h00400010, 0, 0, 4);
    req_c0 = 1'b0;
    chk_quiet("t6_release");
    tick();
    chk_quiet("t6_idle");
    tick();
    chk("t6_next_gnt", gnt_c1, 1);
    burst(1, 32'h00500020, 0, 0, 4);
    req_c1 = 1'b0;
    tick();
    tick();
    chk_quiet("t6_end");
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
